// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer:
//   - default values of the three timing parameters
//   - FSM state type
//   - max3() helper used to size the shared state counter
// No ports (package).
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    // 1 ms at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF  = 100000;
    localparam int unsigned MEM_HOLD_CYCLES_DEF  = 16;
    localparam int unsigned CPU_DELAY_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,  // memories and CPU held in reset
        S_MEM_UP = 2'd1,  // memories released, CPU still held
        S_RUN    = 2'd2   // everything released
    } state_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a counting debouncer for one raw
// pushbutton. The accepted level only changes after the synchronized input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   btn_i    in   raw asynchronous button, active-high
//   level_o  out  debounced button level
//   rise_o   out  one-cycle pulse, coincident with level_o going 0 -> 1
// -----------------------------------------------------------------------------
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    // NOTE: every variable assigned in always_comb gets a default on entry so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                rise_d   = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Power-on / pushbutton reset sequencer. Holds memories and CPU in reset,
// releases memories after MEM_HOLD_CYCLES, then the CPU after a further
// CPU_DELAY_CYCLES. A debounced button press restarts the sequence and holds
// it in S_HOLD while the button stays pressed.
//
// Optional feature (macro RST_SEQ_STEP_MODE_EN): single-step mode. With the
// synced mode switch high, cpu_en in S_RUN only pulses for one cycle per
// debounced rising edge of the step button.
//
// Ports:
//   clk         in   system clock (PLL output)
//   reset       in   synchronous, active-high
//   btn_rst_i   in   raw reset pushbutton, active-high
//   btn_step_i  in   raw step pushbutton (RST_SEQ_STEP_MODE_EN only)
//   sw_step_i   in   step-mode switch     (RST_SEQ_STEP_MODE_EN only)
//   mem_rst     out  memory/peripheral reset, active-high
//   cpu_rst     out  CPU reset, active-high
//   cpu_en      out  CPU clock-enable
//   seq_busy    out  high whenever the FSM is not in S_RUN
// -----------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned MEM_HOLD_CYCLES  = MEM_HOLD_CYCLES_DEF,
    parameter int unsigned CPU_DELAY_CYCLES = CPU_DELAY_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_rst_i,
`ifdef RST_SEQ_STEP_MODE_EN
    input  logic btn_step_i,
    input  logic sw_step_i,
`endif
    output logic mem_rst,
    output logic cpu_rst,
    output logic cpu_en,
    output logic seq_busy
);

    localparam int unsigned CNT_W =
        $clog2(max3(DEBOUNCE_CYCLES, MEM_HOLD_CYCLES, CPU_DELAY_CYCLES));
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_DELAY_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || MEM_HOLD_CYCLES < 2 || CPU_DELAY_CYCLES < 2)
    begin : g_param_check
        $error("rst_seq_ctrl: all cycle parameters must be >= 2");
    end

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic btn_rst_level;
    logic btn_rst_rise_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_rst (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_rst_i),
        .level_o (btn_rst_level),
        .rise_o  (btn_rst_rise_unused)
    );

`ifdef RST_SEQ_STEP_MODE_EN
    logic       step_rise;
    logic       step_level_unused;
    logic [1:0] sw_step_sync_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_step (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_step_i),
        .level_o (step_level_unused),
        .rise_o  (step_rise)
    );

    // The mode switch is a slide switch: synchronize only, no debounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_step_sync_q <= '0;
        end else begin
            sw_step_sync_q <= {sw_step_sync_q[0], sw_step_i};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (btn_rst_level) begin
            // Button wins over everything and pins the counter at zero, so
            // the hold time is measured from the debounced release.
            state_d = S_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == MEM_LAST) begin
                        state_d = S_MEM_UP;
                        cnt_d   = '0;
                    end
                end
                S_MEM_UP: begin
                    if (cnt_q == CPU_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so each output
    // changes on the same edge that commits the state transition.
    // ------------------------------------------------------------------
    logic mem_rst_q, mem_rst_d;
    logic cpu_rst_q, cpu_rst_d;
    logic cpu_en_q,  cpu_en_d;
    logic busy_q,    busy_d;

    always_comb begin
        mem_rst_d = (state_d == S_HOLD);
        cpu_rst_d = (state_d != S_RUN);
        busy_d    = (state_d != S_RUN);
`ifdef RST_SEQ_STEP_MODE_EN
        // A step edge is a one-cycle pulse; one arriving outside S_RUN simply
        // expires, so nothing is queued.
        cpu_en_d  = (state_d == S_RUN) && (!sw_step_sync_q[1] || step_rise);
`else
        cpu_en_d  = (state_d == S_RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            mem_rst_q <= 1'b1;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_rst_q <= mem_rst_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_rst  = mem_rst_q;
    assign cpu_rst  = cpu_rst_q;
    assign cpu_en   = cpu_en_q;
    assign seq_busy = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Directed bench for rst_seq_ctrl with DEBOUNCE_CYCLES=4, MEM_HOLD_CYCLES=3,
// CPU_DELAY_CYCLES=5. Each stimulus step pushes the output vector expected
// for the current cycle; a checker pops and compares on the falling edge.
// Output vector: {mem_rst, cpu_rst, cpu_en, seq_busy}.
// Define RST_SEQ_STEP_MODE_EN to also exercise single-step mode.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    localparam logic [3:0] V_HOLD  = 4'b1101;
    localparam logic [3:0] V_MEMUP = 4'b0101;
    localparam logic [3:0] V_RUN   = 4'b0010;
    localparam logic [3:0] V_STEP  = 4'b0000;  // S_RUN, step mode, no pulse

    typedef struct {
        string      tag;
        logic [3:0] want;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_rst_i;
    logic mem_rst, cpu_rst, cpu_en, seq_busy;
`ifdef RST_SEQ_STEP_MODE_EN
    logic btn_step_i;
    logic sw_step_i;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    sb_entry_t sb[$];

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .MEM_HOLD_CYCLES  (3),
        .CPU_DELAY_CYCLES (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_rst_i  (btn_rst_i),
`ifdef RST_SEQ_STEP_MODE_EN
        .btn_step_i (btn_step_i),
        .sw_step_i  (sw_step_i),
`endif
        .mem_rst    (mem_rst),
        .cpu_rst    (cpu_rst),
        .cpu_en     (cpu_en),
        .seq_busy   (seq_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard consumer: outputs settle after the rising edge.
    always @(negedge clk) begin
        sb_entry_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, {28'b0, mem_rst, cpu_rst, cpu_en, seq_busy},
                  {28'b0, e.want});
        end
    end

    // Push the expectation for the current cycle, then advance one clock.
    task automatic step(input string tag, input int n, input logic [3:0] want);
        sb_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.tag  = tag;
            e.want = want;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        btn_rst_i = 1'b0;
`ifdef RST_SEQ_STEP_MODE_EN
        btn_step_i = 1'b0;
        sw_step_i  = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Reset state, then the full 3/5 power-up sequence.
        step("reset_state", 3, V_HOLD);
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        step("pwrup_hold", 3, V_HOLD);
        step("pwrup_memup", 5, V_MEMUP);
        step("pwrup_run", 4, V_RUN);

        // Short glitch: 2 cycles is below the debounce window.
        btn_rst_i = 1'b1;
        step("glitch_run", 2, V_RUN);
        btn_rst_i = 1'b0;
        step("glitch_run", 10, V_RUN);

        // Long press: resets assert 2+4+1 cycles later, hold while pressed,
        // then the full sequence replays after the debounced release.
        btn_rst_i = 1'b1;
        step("press_delay", 7, V_RUN);
        step("press_hold", 13, V_HOLD);
        btn_rst_i = 1'b0;
        step("release_hold", 9, V_HOLD);
        step("release_memup", 5, V_MEMUP);
        step("release_run", 5, V_RUN);

        // Synchronous reset from S_RUN, then again in S_MEM_UP at cnt=2.
        reset = 1'b1;
        step("rst_run_edge", 1, V_RUN);
        reset = 1'b0;
        step("rst_run_hold", 3, V_HOLD);
        step("rst_run_memup", 2, V_MEMUP);
        check("memup_cnt2", 32'(dut.cnt_q), 32'd2);
        reset = 1'b1;
        step("rst_memup_edge", 1, V_MEMUP);
        check("rst_memup_cnt", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        step("rst_memup_hold", 3, V_HOLD);
        step("rst_memup_memup", 5, V_MEMUP);
        step("rst_memup_run", 4, V_RUN);

`ifdef RST_SEQ_STEP_MODE_EN
        // Enter step mode: cpu_en drops after the 2-flop sync plus the
        // output register.
        sw_step_i = 1'b1;
        step("step_enter", 3, V_RUN);
        step("step_idle", 3, V_STEP);

        // Three debounced step presses -> three single-cycle pulses.
        for (int k = 0; k < 3; k++) begin
            btn_step_i = 1'b1;
            step("step_wait", 7, V_STEP);
            step("step_pulse", 1, V_RUN);
            btn_step_i = 1'b0;
            step("step_after", 10, V_STEP);
        end

        // Step press while held in S_HOLD is discarded.
        btn_rst_i = 1'b1;
        step("sh_delay", 7, V_STEP);
        step("sh_hold", 3, V_HOLD);
        btn_step_i = 1'b1;
        step("sh_step_press", 8, V_HOLD);
        btn_step_i = 1'b0;
        step("sh_step_release", 8, V_HOLD);
        btn_rst_i = 1'b0;
        step("sh_rel_hold", 9, V_HOLD);
        step("sh_rel_memup", 5, V_MEMUP);
        step("sh_run_nopulse", 10, V_STEP);

        // Leave step mode: cpu_en returns to following S_RUN.
        sw_step_i = 1'b0;
        step("step_exit", 3, V_STEP);
        step("step_exit_run", 3, V_RUN);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000; the number of cycles a button input must stay stable before it is accepted (1 ms at 100 MHz).
REQ-002 Parameter MEM_HOLD_CYCLES, default 16; the number of cycles mem_rst stays asserted after the sequence starts.
REQ-003 Parameter CPU_DELAY_CYCLES, default 16; the number of cycles cpu_rst stays asserted after mem_rst releases.
REQ-004 clk  in  1  single system clock, taken from the PLL output.
REQ-005 reset  in  1  synchronous, active-high; driven by the inverted PLL-lock-qualified reset_n.
REQ-006 btn_rst_i  in  1  raw asynchronous reset pushbutton, active-high.
REQ-007 mem_rst  out  1  active-high reset for memories and peripherals.
REQ-008 cpu_rst  out  1  active-high reset for the CPU core.
REQ-009 cpu_en  out  1  CPU clock-enable.
REQ-010 seq_busy  out  1  high whenever the FSM is not in S_RUN.

Function
REQ-011 btn_rst_i SHALL pass through a 2-flop synchronizer, then a debouncer.
- The debouncer holds a stable value and a counter.
- The counter clears whenever the synced value equals the stable value.
- Otherwise the counter increments; the stable value updates at count DEBOUNCE_CYCLES-1.
REQ-012 The FSM SHALL have three states:
- S_HOLD: mem_rst=1, cpu_rst=1.
- S_MEM_UP: mem_rst=0, cpu_rst=1.
- S_RUN: mem_rst=0, cpu_rst=0.
REQ-013 S_HOLD -> S_MEM_UP SHALL occur when cnt==MEM_HOLD_CYCLES-1 and the debounced button is low.
REQ-014 S_MEM_UP -> S_RUN SHALL occur when cnt==CPU_DELAY_CYCLES-1.
REQ-015 The shared state counter SHALL clear on every state entry.
REQ-016 A debounced button level high in any state SHALL force S_HOLD with cnt=0, and SHALL hold S_HOLD for as long as it stays high.
REQ-017 All outputs SHALL be registered; an output changes in the cycle after its state transition.
REQ-018 After reset deasserts with the button idle, mem_rst SHALL stay high for exactly MEM_HOLD_CYCLES cycles, then cpu_rst for exactly CPU_DELAY_CYCLES further cycles.
REQ-019 cpu_en SHALL be 1 only in S_RUN (subject to REQ-025).
REQ-020 Counter width SHALL be $clog2 of the largest of the three parameters.
- Each parameter SHALL be >=2; violating this is an elaboration error.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no state change.

Reset
REQ-022 While reset is high, the following SHALL hold:
- FSM=S_HOLD, cnt=0.
- Debounce stable values=0, debounce counters=0, synchronizers=0.
- mem_rst=1, cpu_rst=1, cpu_en=0, seq_busy=1.
REQ-023 reset asserted mid-sequence or in S_RUN SHALL take effect on the next clk edge and restart the full sequence on release.

Configuration
REQ-024 Macro RST_SEQ_STEP_MODE_EN SHALL add two ports:
- btn_step_i: raw step pushbutton, debounced per REQ-011.
- sw_step_i: mode switch, 2-flop synchronized only, no debounce.
REQ-025 With RST_SEQ_STEP_MODE_EN defined and synced sw_step_i=1, cpu_en SHALL behave as follows:
- In S_RUN, cpu_en is 0 except for exactly one 1-cycle pulse per rising edge of debounced btn_step_i.
- Step edges outside S_RUN are discarded, not queued.
- With sw_step_i=0, cpu_en follows REQ-019.
REQ-026 Without the macro, neither port SHALL exist and cpu_en SHALL follow REQ-019 only.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the state enum type (S_HOLD, S_MEM_UP, S_RUN) and the default values of the three parameters.
REQ-028 Sub-module btn_debounce (synchronizer, debouncer, rising-edge pulse output) SHALL be instantiated once for btn_rst_i, plus once for btn_step_i when the macro is defined.

Verification (DEBOUNCE_CYCLES=4, MEM_HOLD_CYCLES=3, CPU_DELAY_CYCLES=5)
REQ-029 Release reset with the button low -> mem_rst high for 3 cycles, then cpu_rst high for 5 more cycles, then cpu_en=1 and seq_busy=0.
REQ-030 In S_RUN, pulse btn_rst_i high for 2 cycles -> no output change.
REQ-031 In S_RUN, hold btn_rst_i high for 20 cycles, then release:
- Both resets assert 2+4+1 cycles after the press.
- They stay asserted while the debounced level is high.
- The full 3/5 sequence replays after the debounced release.
REQ-032 Assert reset during S_MEM_UP at cnt=2 -> the next cycle shows mem_rst=1 and cnt=0; on release, a full 3+5 sequence follows.
REQ-033 With RST_SEQ_STEP_MODE_EN, sw_step_i=1, in S_RUN:
- 3 debounced step presses produce exactly 3 single-cycle cpu_en pulses.
- A step press during S_HOLD produces no pulse.
